// File: rtl/osc_phase_gen.sv
// osc_phase_gen: note-table phase counter with periodic count/dsor snapshots for the divider.
// Optional OSC_DETUNE_EN adds a signed 4-bit detune input latched alongside key/octave.
module osc_phase_gen #(
  parameter int SAMPLE_PERIOD = 256,
  parameter int PHASE_W = 19
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [3:0]         key,
  input  logic [1:0]         octave,
`ifdef OSC_DETUNE_EN
  input  logic [3:0]         detune,
`endif
  output logic [PHASE_W-1:0] count,
  output logic [PHASE_W-1:0] dsor,
  output logic               sample,
  output logic               note_valid
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [15:0] BASE [16] = '{
    16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635,
    16'd27027, 16'd25511, 16'd24079, 16'd22727, 16'd21452, 16'd20248,
    16'd0, 16'd0, 16'd0, 16'd0};
  logic [3:0] det_in, pkey, akey, pdet, adet;
  logic [1:0] poct, aoct;
  logic [TW-1:0] tick;
  logic [PHASE_W-1:0] phase, active_div;
  logic active_valid, wrap, load, snap;
`ifdef OSC_DETUNE_EN
  assign det_in = detune;
`else
  assign det_in = '0;
`endif
  always_comb begin
    active_valid = akey < 4'd12;
    active_div = PHASE_W'(BASE[akey] >> aoct) + {{(PHASE_W-4){adet[3]}}, adet};
    wrap = active_valid && phase == active_div - 1'b1;
    load = wrap || !active_valid;
    snap = active_valid && tick == '1;
  end
  // pending note is captured every cycle, reset included, so a held key starts right after release
  always_ff @(posedge clk) begin
    pkey <= key;
    poct <= octave;
    pdet <= det_in;
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      akey <= 4'hF;
      aoct <= '0;
      adet <= '0;
      phase <= '0;
      tick <= '0;
      sample <= 1'b0;
      count <= '0;
      dsor <= '0;
      note_valid <= 1'b0;
    end else begin
      tick <= tick + 1'b1;
      phase <= load ? '0 : phase + 1'b1;
      sample <= snap;
      if (load) begin
        akey <= pkey;
        aoct <= poct;
        adet <= pdet;
        note_valid <= pkey < 4'd12;
      end
      if (snap) begin
        count <= phase;
        dsor <= active_div;
      end
    end
  end
endmodule

// File: tb/tb_osc_phase_gen.sv
// tb_osc_phase_gen: directed checks of reset, steady run, note change, octave, silence and mid-run reset.
module tb_osc_phase_gen;
  logic clk = 1'b0, RST = 1'b1, sample, note_valid;
  logic [3:0] key = 4'd9;
  logic [1:0] octave = 2'd0;
  logic [18:0] count, dsor;
`ifdef OSC_DETUNE_EN
  logic [3:0] detune = 4'd0;
  localparam int DIV3 = 2832;
`else
  localparam int DIV3 = 2840;
`endif
  int errs = 0, checks = 0, j = 0;

  osc_phase_gen dut (
    .clk(clk), .RST(RST), .key(key), .octave(octave),
`ifdef OSC_DETUNE_EN
    .detune(detune),
`endif
    .count(count), .dsor(dsor), .sample(sample), .note_valid(note_valid));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    j += n;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] k, input logic [1:0] o);
    RST = 1'b1; key = k; octave = o;
    step(3);
    RST = 1'b0;
    j = 0;
  endtask

  task automatic test_reset;
    RST = 1'b1; key = 4'd9; octave = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({sample, note_valid, count, dsor} !== 40'd0)
        begin errs++; $display("FAIL reset_hold: s=%0d nv=%0d count=%0d dsor=%0d want all 0", sample, note_valid, count, dsor); end
    end
    RST = 1'b0; j = 0;
    step(1);
    checks++;
    if (note_valid !== 1'b1) begin errs++; $display("FAIL reset_nv: got %0d want 1", note_valid); end
    step(254);
    checks++;
    if (sample !== 1'b0) begin errs++; $display("FAIL reset_early: sample=%0d at j=%0d want 0", sample, j); end
    step(1);
    checks++;
    if (sample !== 1'b1 || count !== 19'd254 || dsor !== 19'd22727)
      begin errs++; $display("FAIL reset_first: s=%0d count=%0d dsor=%0d want 1/254/22727", sample, count, dsor); end
  endtask

  task automatic test_steady;
    int prev = 254, exp;
    for (int n = 2; n <= 101; n++) begin
      step(1);
      checks++;
      if (sample !== 1'b0) begin errs++; $display("FAIL steady_width: sample=%0d j=%0d want 0", sample, j); end
      step(254);
      checks++;
      if (sample !== 1'b0) begin errs++; $display("FAIL steady_gap: sample=%0d j=%0d want 0", sample, j); end
      step(1);
      exp = (prev + 256) % 22727;
      checks++;
      if (sample !== 1'b1 || count !== 19'(exp) || count >= 19'd22727)
        begin errs++; $display("FAIL steady_pulse: n=%0d s=%0d count=%0d want 1/%0d", n, sample, count, exp); end
      checks++;
      if (dsor !== 19'd22727) begin errs++; $display("FAIL steady_dsor: n=%0d got %0d want 22727", n, dsor); end
      prev = exp;
    end
  endtask

  task automatic test_key_change;
    key = 4'd0;
    for (int n = 102; n <= 177; n++) begin
      step(256);
      checks++;
      if (sample !== 1'b1 || dsor !== 19'd22727 || count !== 19'((256 * n - 2) % 22727))
        begin errs++; $display("FAIL change_old: n=%0d s=%0d count=%0d dsor=%0d want 1/%0d/22727", n, sample, count, dsor, (256 * n - 2) % 22727); end
    end
    step(256);
    checks++;
    if (sample !== 1'b1 || dsor !== 19'd38223 || count !== 19'd112)
      begin errs++; $display("FAIL change_new: s=%0d count=%0d dsor=%0d want 1/112/38223", sample, count, dsor); end
  endtask

  task automatic test_octave;
`ifdef OSC_DETUNE_EN
    detune = 4'b1000;
`endif
    do_reset(4'd9, 2'd3);
    for (int n = 1; n <= 12; n++) begin
      step(256);
      checks++;
      if (sample !== 1'b1 || dsor !== 19'(DIV3) || count !== 19'((256 * n - 2) % DIV3))
        begin errs++; $display("FAIL octave: n=%0d s=%0d count=%0d dsor=%0d want 1/%0d/%0d", n, sample, count, dsor, (256 * n - 2) % DIV3, DIV3); end
    end
  endtask

  task automatic test_silence;
    int w = 2 * DIV3 + 1, last = 5630 % DIV3, ji, p;
    bit bad = 0;
    key = 4'd15;
    for (int n = 13; n <= 22; n++) begin
      step(256);
      checks++;
      if (sample !== 1'b1 || dsor !== 19'(DIV3) || count !== 19'((256 * n - 2) % DIV3))
        begin errs++; $display("FAIL pre_silence: n=%0d s=%0d count=%0d want 1/%0d", n, sample, count, (256 * n - 2) % DIV3); end
    end
    step(w - 1 - j);
    checks++;
    if (note_valid !== 1'b1) begin errs++; $display("FAIL silence_before_wrap: nv=%0d want 1", note_valid); end
    step(1);
    checks++;
    if (note_valid !== 1'b0) begin errs++; $display("FAIL silence_at_wrap: nv=%0d want 0", note_valid); end
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (sample !== 1'b0 || note_valid !== 1'b0 || count !== 19'(last) || dsor !== 19'(DIV3)) bad = 1;
    end
    checks++;
    if (bad) begin errs++; $display("FAIL silence_hold: s=%0d nv=%0d count=%0d dsor=%0d want 0/0/%0d/%0d", sample, note_valid, count, dsor, last, DIV3); end
    key = 4'd4; octave = 2'd0;
`ifdef OSC_DETUNE_EN
    detune = 4'd0;
`endif
    step(2);
    checks++;
    if (note_valid !== 1'b1) begin errs++; $display("FAIL resume_nv: nv=%0d want 1", note_valid); end
    ji = j;
    p = (ji / 256 + 1) * 256;
    step(p - ji - 1);
    checks++;
    if (sample !== 1'b0) begin errs++; $display("FAIL resume_early: sample=%0d want 0", sample); end
    step(1);
    checks++;
    if (sample !== 1'b1 || dsor !== 19'd30337 || count !== 19'(p - ji - 1))
      begin errs++; $display("FAIL resume_pulse: s=%0d count=%0d dsor=%0d want 1/%0d/30337", sample, count, dsor, p - ji - 1); end
  endtask

  task automatic test_reset_mid;
    step(255);
    checks++;
    if (sample !== 1'b0 || note_valid !== 1'b1) begin errs++; $display("FAIL mid_pre: s=%0d nv=%0d want 0/1", sample, note_valid); end
    RST = 1'b1;
    step(1);
    checks++;
    if ({sample, note_valid, count, dsor} !== 40'd0)
      begin errs++; $display("FAIL mid_reset: s=%0d nv=%0d count=%0d dsor=%0d want all 0", sample, note_valid, count, dsor); end
    RST = 1'b0; j = 0;
    step(1);
    checks++;
    if (note_valid !== 1'b1) begin errs++; $display("FAIL mid_nv: nv=%0d want 1", note_valid); end
    step(255);
    checks++;
    if (sample !== 1'b1 || count !== 19'd254 || dsor !== 19'd30337)
      begin errs++; $display("FAIL mid_resume: s=%0d count=%0d dsor=%0d want 1/254/30337", sample, count, dsor); end
  endtask

  initial begin
    test_reset;
    test_steady;
    test_key_change;
    test_octave;
    test_silence;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
